// File: rtl/head_deparser.sv
// Header deparser: writes rewritten key fields back into a captured header, then
// streams the rebuilt header out as MSB-first beats with last/keep.
module head_deparser #(
  parameter int HEAD_WIDTH       = 512,
  parameter int KEY_FIELD_WIDTH  = 16,
  parameter int KEY_FILED_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 5,
  parameter int OUT_WIDTH        = 128
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_head_valid,
  output logic                                          o_head_ready,
  input  logic [HEAD_WIDTH-1:0]                         i_head,
  input  logic [KEY_FILED_NUM*KEY_FIELD_WIDTH-1:0]      i_key_field,
  input  logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_key_offset,
  input  logic [KEY_OFFSET_WIDTH:0]                     i_head_len,
  output logic                                          o_data_valid,
  input  logic                                          i_data_ready,
  output logic [OUT_WIDTH-1:0]                          o_data,
  output logic                                          o_data_last,
  output logic [OUT_WIDTH/8-1:0]                        o_data_keep,
  output logic [31:0]                                   o_pkt_cnt
);

  localparam int UNITS      = HEAD_WIDTH / KEY_FIELD_WIDTH;
  localparam int OFF_W      = KEY_OFFSET_WIDTH + 1;
  localparam int BEATS      = HEAD_WIDTH / OUT_WIDTH;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OUT_BYTES  = OUT_WIDTH / 8;
  localparam int UNIT_BYTES = KEY_FIELD_WIDTH / 8;
  localparam int BYTE_W     = $clog2(HEAD_WIDTH / 8) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [HEAD_WIDTH-1:0]                    head_reg;
  logic [HEAD_WIDTH-1:0]                    merged_reg;
  logic [HEAD_WIDTH-1:0]                    merged_next;
  logic [KEY_FILED_NUM*KEY_FIELD_WIDTH-1:0] field_reg;
  logic [KEY_FILED_NUM*OFF_W-1:0]           offset_reg;
  logic [OFF_W-1:0]                         len_reg;
  logic [OFF_W-1:0]                         len_norm;
  logic [IDX_W-1:0]                         beat_idx_reg;
  logic [IDX_W-1:0]                         last_idx_reg;
  logic [IDX_W-1:0]                         last_idx_next;
  logic [31:0]                              pkt_cnt_reg;
  logic                                     is_last;
  logic                                     beat_done;
  logic [BYTE_W-1:0]                        beat_base;
  logic [BYTE_W-1:0]                        len_bytes;
  logic [OUT_WIDTH-1:0]                     beat_word [BEATS];

  // Zero or oversize lengths fall back to a full header.
  assign len_norm = (i_head_len == '0 || i_head_len > OFF_W'(UNITS)) ? OFF_W'(UNITS) : i_head_len;
  assign last_idx_next = IDX_W'((32'(len_reg) * KEY_FIELD_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    o_head_ready = 1'b0;
    o_data_valid = 1'b0;
    is_last      = 1'b0;
    case (state_reg)
      IDLE: begin
        o_head_ready = 1'b1;
        if (i_head_valid) state_next = MERGE;
      end
      MERGE: state_next = SEND;
      SEND: begin
        o_data_valid = 1'b1;
        is_last      = (beat_idx_reg == last_idx_reg);
        if (i_data_ready && is_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat_done = o_data_valid & i_data_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_reg     <= '0;
      field_reg    <= '0;
      offset_reg   <= '0;
      len_reg      <= '0;
      merged_reg   <= '0;
      beat_idx_reg <= '0;
      last_idx_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else begin
      if (state_reg == IDLE && i_head_valid) begin
        head_reg   <= i_head;
        field_reg  <= i_key_field;
        offset_reg <= i_key_offset;
        len_reg    <= len_norm;
      end
      if (state_reg == MERGE) begin
        merged_reg   <= merged_next;
        last_idx_reg <= last_idx_next;
        beat_idx_reg <= '0;
      end
      if (beat_done) begin
        if (is_last) begin
          pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
        end else begin
          beat_idx_reg <= beat_idx_reg + 1'b1;
        end
      end
    end
  end

  // Per 16b unit: later (higher-index) enabled fields override earlier ones,
  // and units past the header length are cleared so beats need no extra masking.
  for (genvar gi = 0; gi < UNITS; gi++) begin : g_unit
    logic [KEY_FIELD_WIDTH-1:0] unit_word;
    always_comb begin
      unit_word = head_reg[HEAD_WIDTH-1-KEY_FIELD_WIDTH*gi -: KEY_FIELD_WIDTH];
      for (int i = 0; i < KEY_FILED_NUM; i++) begin
        if (offset_reg[OFF_W*i+KEY_OFFSET_WIDTH] &&
            offset_reg[OFF_W*i +: KEY_OFFSET_WIDTH] == KEY_OFFSET_WIDTH'(gi)) begin
          unit_word = field_reg[KEY_FIELD_WIDTH*i +: KEY_FIELD_WIDTH];
        end
      end
      if (OFF_W'(gi) >= len_reg) unit_word = '0;
    end
    assign merged_next[HEAD_WIDTH-1-KEY_FIELD_WIDTH*gi -: KEY_FIELD_WIDTH] = unit_word;
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_word[gi] = merged_reg[HEAD_WIDTH-1-OUT_WIDTH*gi -: OUT_WIDTH];
  end

  assign beat_base = BYTE_W'(beat_idx_reg) * BYTE_W'(OUT_BYTES);
  assign len_bytes = BYTE_W'(len_reg) * BYTE_W'(UNIT_BYTES);

  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_keep
    assign o_data_keep[OUT_BYTES-1-gi] = o_data_valid && ((beat_base + BYTE_W'(gi)) < len_bytes);
  end

  assign o_data      = o_data_valid ? beat_word[beat_idx_reg] : '0;
  assign o_data_last = is_last;
  assign o_pkt_cnt   = pkt_cnt_reg;

endmodule
